// File: rtl/stopwatch_btn_ctrl.sv
// Stopwatch button front end: synchronise, debounce and edge-detect buttons, then drive run/clr_n/freeze.
// Lap-hold (btn_lap -> freeze) is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_btn_ctrl #(
    parameter int DEBOUNCE_CYCLES = 32'sd500_000,
    parameter int CLR_PULSE       = 32'sd16
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_start,
    input  logic       btn_reset,
    input  logic       btn_lap,
    output logic       run,
    output logic       clr_n,
    output logic       freeze,
    output logic [1:0] state
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = (CLR_PULSE > 32'sd1) ? $clog2(CLR_PULSE) : 32'sd1;
    localparam int B_START = 32'sd0;
    localparam int B_RESET = 32'sd1;
`ifdef STOPWATCH_LAP_EN
    localparam int B_LAP   = 32'sd2;
    localparam int NBTN    = 32'sd3;
`else
    localparam int NBTN    = 32'sd2;
`endif

    typedef enum logic [1:0] {
        ST_CLEARING = 2'd0,
        ST_IDLE     = 2'd1,
        ST_RUNNING  = 2'd2,
        ST_PAUSED   = 2'd3
    } state_t;

    logic [NBTN-1:0] raw_s;
    logic [NBTN-1:0] sync1_q;
    logic [NBTN-1:0] sync2_q;
    logic [NBTN-1:0] acc_q;
    logic [NBTN-1:0] acc_d;
    logic [NBTN-1:0] acc_prev_q;
    logic [NBTN-1:0] press_s;
    logic [DW-1:0]   cnt_q [NBTN];
    logic [DW-1:0]   cnt_d [NBTN];

    state_t          state_q;
    state_t          state_d;
    logic [PW-1:0]   pcnt_q;
    logic [PW-1:0]   pcnt_d;
    logic            run_q;
    logic            run_d;
    logic            clr_n_q;
    logic            clr_n_d;
    logic            freeze_q;
    logic            freeze_d;

`ifdef STOPWATCH_LAP_EN
    assign raw_s = {btn_lap, btn_reset, btn_start};
`else
    logic unused_lap_s;
    assign unused_lap_s = btn_lap;
    assign raw_s        = {btn_reset, btn_start};
`endif

    // Debounce: the accepted level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        for (int i = 0; i < NBTN; i++) begin
            acc_d[i] = acc_q[i];
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == acc_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 32'sd1)) begin
                acc_d[i] = ~acc_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DW'(1'b1);
            end
        end
    end

    assign press_s = acc_q & ~acc_prev_q;

    // Synchroniser, accepted-level and debounce-counter registers; untouched by the CLEARING state.
    always_ff @(posedge clk) begin
        if (clr) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            acc_q      <= '0;
            acc_prev_q <= '0;
            for (int i = 0; i < NBTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= raw_s;
            sync2_q    <= sync1_q;
            acc_q      <= acc_d;
            acc_prev_q <= acc_q;
            for (int i = 0; i < NBTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Next state and next outputs; outputs are derived from the state being entered.
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        case (state_q)
            ST_CLEARING: begin
                if (pcnt_q == PW'(CLR_PULSE - 32'sd1)) begin
                    state_d = ST_IDLE;
                    pcnt_d  = '0;
                end else begin
                    pcnt_d  = pcnt_q + PW'(1'b1);
                end
            end
            ST_IDLE: begin
                if (press_s[B_RESET]) begin
                    state_d = ST_CLEARING;
                    pcnt_d  = '0;
                end else if (press_s[B_START]) begin
                    state_d = ST_RUNNING;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUNNING: begin
                // Reset is deliberately dropped while counting; only start/stop acts here.
                if (press_s[B_START]) begin
                    state_d = ST_PAUSED;
                end else begin
                    state_d = ST_RUNNING;
                end
            end
            ST_PAUSED: begin
                if (press_s[B_RESET]) begin
                    state_d = ST_CLEARING;
                    pcnt_d  = '0;
                end else if (press_s[B_START]) begin
                    state_d = ST_RUNNING;
                end else begin
                    state_d = ST_PAUSED;
                end
            end
            default: begin
                state_d = ST_CLEARING;
                pcnt_d  = '0;
            end
        endcase

`ifdef STOPWATCH_LAP_EN
        if (state_d == ST_CLEARING) begin
            freeze_d = 1'b0;
        end else if (press_s[B_LAP] && ((state_q == ST_RUNNING) || (state_q == ST_PAUSED))) begin
            freeze_d = ~freeze_q;
        end else begin
            freeze_d = freeze_q;
        end
`else
        freeze_d = 1'b0;
`endif

        run_d   = (state_d == ST_RUNNING);
        clr_n_d = (state_d != ST_CLEARING);
    end

    // FSM state, clear-pulse counter and registered outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= ST_CLEARING;
            pcnt_q   <= '0;
            run_q    <= 1'b0;
            clr_n_q  <= 1'b0;
            freeze_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            run_q    <= run_d;
            clr_n_q  <= clr_n_d;
            freeze_q <= freeze_d;
        end
    end

    assign run    = run_q;
    assign clr_n  = clr_n_q;
    assign freeze = freeze_q;
    assign state  = state_q;

endmodule

// File: tb/tb_stopwatch_btn_ctrl.sv
// Scoreboard bench for stopwatch_btn_ctrl: directed scenarios plus random button traffic,
// checked every cycle against a delay-line / sliding-window reference model.
module tb_stopwatch_btn_ctrl;

    localparam int D = 4;
    localparam int P = 3;
    localparam int S_CLEARING = 0;
    localparam int S_IDLE     = 1;
    localparam int S_RUNNING  = 2;
    localparam int S_PAUSED   = 3;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_reset = 1'b0;
    logic       btn_lap = 1'b0;
    logic       run;
    logic       clr_n;
    logic       freeze;
    logic [1:0] state;

    stopwatch_btn_ctrl #(.DEBOUNCE_CYCLES(D), .CLR_PULSE(P)) dut (
        .clk       (clk),
        .clr       (clr),
        .btn_start (btn_start),
        .btn_reset (btn_reset),
        .btn_lap   (btn_lap),
        .run       (run),
        .clr_n     (clr_n),
        .freeze    (freeze),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic       run;
        logic       clr_n;
        logic       freeze;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    // Reference model state
    int m_state = S_CLEARING;
    int m_left  = 0;
    bit m_freeze = 1'b0;
    bit m_acc[3];
    bit m_pend[3];
    bit m_dly[3][$];
    bit m_win[3][$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge of the reference model.
    task automatic model_step(input bit c, input bit [2:0] raw);
        bit ps, pr, pl, all_diff, d;
        int prev;
        if (c) begin
            m_state  = S_CLEARING;
            m_left   = P;
            m_freeze = 1'b0;
            for (int b = 0; b < 3; b++) begin
                m_acc[b]  = 1'b0;
                m_pend[b] = 1'b0;
                m_dly[b]  = {1'b0, 1'b0};
                m_win[b].delete();
            end
            return;
        end
        ps = m_pend[0];
        pr = m_pend[1];
        pl = m_pend[2] & LAP_EN;
        prev = m_state;
        case (m_state)
            S_CLEARING: begin
                m_left--;
                if (m_left == 0) m_state = S_IDLE;
            end
            S_IDLE: begin
                if (pr) begin m_state = S_CLEARING; m_left = P; end
                else if (ps) m_state = S_RUNNING;
            end
            S_RUNNING: if (ps) m_state = S_PAUSED;
            default: begin
                if (pr) begin m_state = S_CLEARING; m_left = P; end
                else if (ps) m_state = S_RUNNING;
            end
        endcase
        if (m_state == S_CLEARING) m_freeze = 1'b0;
        else if (pl && (prev == S_RUNNING || prev == S_PAUSED)) m_freeze = ~m_freeze;
        // Button path: 2-deep delay line, then accept after D straight disagreeing samples.
        for (int b = 0; b < 3; b++) begin
            d = m_dly[b].pop_front();
            m_dly[b].push_back(raw[b]);
            m_win[b].push_back(d);
            if (m_win[b].size() > D) void'(m_win[b].pop_front());
            m_pend[b] = 1'b0;
            all_diff = (m_win[b].size() == D);
            for (int i = 0; i < m_win[b].size(); i++)
                if (m_win[b][i] == m_acc[b]) all_diff = 1'b0;
            if (all_diff) begin
                m_acc[b]  = ~m_acc[b];
                m_win[b].delete();
                m_pend[b] = m_acc[b];
            end
        end
    endtask

    task automatic cycle(input bit c, input bit s, input bit r, input bit l);
        exp_t e;
        @(negedge clk);
        clr = c; btn_start = s; btn_reset = r; btn_lap = l;
        model_step(c, {l, r, s});
        e.st     = 2'(m_state);
        e.run    = (m_state == S_RUNNING);
        e.clr_n  = (m_state != S_CLEARING);
        e.freeze = m_freeze;
        sb.push_back(e);
    endtask

    task automatic hold(input bit c, input bit s, input bit r, input bit l, input int n);
        repeat (n) cycle(c, s, r, l);
    endtask

    task automatic press(input bit s, input bit r, input bit l);
        hold(1'b0, s, r, l, 10);
        hold(1'b0, 1'b0, 1'b0, 1'b0, 10);
    endtask

    // Monitor: compare every presented output cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("state",  32'(state),  32'(e.st));
                chk("run",    32'(run),    32'(e.run));
                chk("clr_n",  32'(clr_n),  32'(e.clr_n));
                chk("freeze", 32'(freeze), 32'(e.freeze));
            end
        end
    end

    initial begin
        bit s, r, l, c;
        int n;
        // Reset: two cycles of clr, then the clear pulse into IDLE.
        hold(1'b1, 1'b0, 1'b0, 1'b0, 2);
        hold(1'b0, 1'b0, 1'b0, 1'b0, 8);
        // Start latency with a long hold.
        hold(1'b0, 1'b1, 1'b0, 1'b0, 100);
        hold(1'b0, 1'b0, 1'b0, 1'b0, 10);
        // Bounce rejection, then one clean press.
        hold(1'b0, 1'b1, 1'b0, 1'b0, 3);
        hold(1'b0, 1'b0, 1'b0, 1'b0, 3);
        hold(1'b0, 1'b1, 1'b0, 1'b0, 3);
        hold(1'b0, 1'b0, 1'b0, 1'b0, 10);
        press(1'b1, 1'b0, 1'b0);
        // Simultaneous start+reset in PAUSED, then in RUNNING.
        press(1'b1, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b0);
        // Clear pulse aborted by clr during its second cycle.
        for (int k = 0; k < 40 && m_state != S_CLEARING; k++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        hold(1'b0, 1'b0, 1'b0, 1'b0, 12);
        // Lap toggling in RUNNING and PAUSED, cleared by a reset.
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        // Random button traffic with occasional clr.
        for (int k = 0; k < 400; k++) begin
            s = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 3) == 0);
            l = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 39) == 0);
            n = $urandom_range(1, 9);
            if (c) cycle(1'b1, 1'b0, 1'b0, 1'b0);
            hold(1'b0, s, r, l, n);
        end
        @(posedge clk);
        #2;
        chk("drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_btn_ctrl.md
# stopwatch_btn_ctrl

Front-end control stage for the board stopwatch. It takes raw push-button inputs, synchronises and debounces them, and turns clean presses into a run/pause level and an active-low clear pulse. These outputs drive the `pause` and `clr` inputs of the stopwatch counter/display block. An optional lap-hold output freezes the displayed value while counting continues.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500_000: consecutive stable cycles required before a button level is accepted (≥2).
- `CLR_PULSE`, 16: length of the `clr_n` low pulse in cycles (≥1).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `clr`  in  1  synchronous active-high reset.
- `btn_start`  in  1  raw start/stop button; active-high; asynchronous to `clk`.
- `btn_reset`  in  1  raw reset button; active-high; asynchronous.
- `btn_lap`  in  1  raw lap button; active-high; asynchronous. Ignored unless `STOPWATCH_LAP_EN` is defined.
- `run`  out  1  1 = counter advancing. Drives the counter's `pause` input (0 holds).
- `clr_n`  out  1  active-low clear to the counter.
- `freeze`  out  1  1 = downstream display holds its last value.
- `state`  out  2  encoding: 0 CLEARING, 1 IDLE, 2 RUNNING, 3 PAUSED.

## Operation
- Per button, there are three steps:
  - Two-flop synchroniser.
  - Debouncer. A counter of width clog2(`DEBOUNCE_CYCLES`) resets whenever the synchronised input equals the accepted level. When the input has differed for `DEBOUNCE_CYCLES` consecutive cycles, the accepted level flips and the counter resets.
  - Rising-edge detect on the accepted level. This produces a one-cycle `press` strobe.
- Releases produce no event. A held button produces exactly one press.

FSM:
- **CLEARING**
  - `clr_n`=0 and `run`=0.
  - A pulse counter runs from 0 to `CLR_PULSE`-1, then the FSM goes to IDLE.
  - All presses are ignored.
- **IDLE**
  - start press → RUNNING.
  - reset press → CLEARING.
- **RUNNING**
  - `run`=1.
  - start press → PAUSED.
  - reset press is ignored.
- **PAUSED**
  - `run`=0.
  - start press → RUNNING.
  - reset press → CLEARING.
- Outputs are registered and take effect in the cycle the state is entered.
- Simultaneous start and reset presses:
  - In IDLE or PAUSED, reset wins.
  - In RUNNING, start wins and reset is dropped.
- Accepted levels and debounce counters are not reset by entering CLEARING. Only `clr` resets them.
- Reset mid-operation: asserting `clr` for one cycle aborts any state, including a CLEARING pulse already in progress. On the next cycle the FSM is in CLEARING with the pulse counter at 0, so a full `CLR_PULSE` is restarted.

## Timing
- Reset values (cycle after `clr` sampled high):
  - `state`=CLEARING, `run`=0, `clr_n`=0, `freeze`=0.
  - Accepted levels = 0; all counters = 0.
- While `clr` is high, outputs hold their reset values.
- Clear pulse: `clr_n` stays low for exactly `CLR_PULSE` cycles after `clr` deasserts. It then goes high together with the entry to IDLE.
- Press latency: a raw edge held stable changes `run`/`state` exactly `DEBOUNCE_CYCLES`+3 cycles later. This is 2 cycles synchroniser, `DEBOUNCE_CYCLES` cycles debounce, and 1 cycle FSM register.
- Bounce: any glitch shorter than `DEBOUNCE_CYCLES` cycles produces no press and restarts the qualification window.
- Reset press from PAUSED: `clr_n` falls `DEBOUNCE_CYCLES`+3 cycles after the raw edge and stays low for `CLR_PULSE` cycles.

## Configuration
- Macro: `STOPWATCH_LAP_EN`.
- Defined: `btn_lap` gets its own synchroniser, debouncer and edge detect.
  - A lap press in RUNNING or PAUSED toggles `freeze`, with the same latency as `run`.
  - Lap presses in CLEARING or IDLE are ignored.
  - Entering CLEARING forces `freeze`=0.
  - Start and lap presses in the same cycle are both applied.
- Undefined: no lap logic is instantiated, `btn_lap` is unused, and `freeze` is tied to 0.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `CLR_PULSE`=3.
- **Reset:** `clr` high for 2 cycles, then low → `state`=0 and `clr_n`=0 for 3 cycles, then `state`=1 and `clr_n`=1; `run`=0 throughout.
- **Start latency:** from IDLE, `btn_start` rises at cycle t and is held → `run`=1 and `state`=2 at t+7; holding for 100 cycles gives no further change.
- **Bounce rejection:** `btn_start` toggles 1,0,1,0 with 3-cycle widths, then stays 0 → `run` never changes; then a clean 10-cycle press → `run` toggles once.
- **Reset priority:** in PAUSED, start and reset rise in the same cycle → CLEARING with `clr_n` low 3 cycles, then IDLE. The same stimulus in RUNNING → PAUSED with `clr_n` staying 1.
- **Reset abort:** assert `clr` for 1 cycle during the 2nd cycle of a clear pulse → `clr_n` low for 3 full cycles after deassertion.
- **Lap (with `STOPWATCH_LAP_EN`):** in RUNNING, lap press → `freeze`=1 while `run` stays 1; second press → `freeze`=0; pause then reset → `freeze`=0 on entering CLEARING. Without the macro, `freeze` stays 0 for any `btn_lap`.
